// File: rtl/display_scheduler.sv
// display_scheduler: double-dabble binary-to-BCD conversion of a 0-99 credit value
// driving two seven-segment digit codes, with leading-zero blanking and blink.
module display_scheduler #(
    parameter int BLINK_HALF_PERIOD = 12500000,
    parameter bit LEADING_ZERO_BLANK = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [7:0] i_Value,
    input  logic       i_Value_DV,
    output logic       o_Ready,
    input  logic       i_Blink,
    output logic [3:0] o_Tens_Num,
    output logic [3:0] o_Ones_Num,
    output logic       o_Tens_En,
    output logic       o_Ones_En,
    output logic       o_Done
);
    localparam int CW = $clog2(BLINK_HALF_PERIOD);

    typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

    state_t        state;
    logic [7:0]    sh;
    logic [9:0]    bcd;
    logic [7:0]    adj;
    logic [2:0]    iter;
    logic          tens_blank;
    logic [CW-1:0] blink_cnt;
    logic          phase;

    // hundreds never reaches 5 for an 8-bit input, so only tens/ones need adjusting
    for (genvar n = 0; n < 2; n++) begin : g_adj
        assign adj[4*n +: 4] = bcd[4*n +: 4] >= 4'd5 ? bcd[4*n +: 4] + 4'd3 : bcd[4*n +: 4];
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state      <= IDLE;
            o_Ready    <= 1'b1;
            o_Done     <= 1'b0;
            o_Tens_Num <= 4'd0;
            o_Ones_Num <= 4'd0;
            tens_blank <= LEADING_ZERO_BLANK;
            sh         <= 8'd0;
            bcd        <= 10'd0;
            iter       <= 3'd0;
        end else begin
            o_Done <= 1'b0;
            case (state)
                IDLE: if (i_Value_DV) begin
                    sh      <= i_Value;
                    bcd     <= 10'd0;
                    iter    <= 3'd0;
                    o_Ready <= 1'b0;
                    state   <= CONVERT;
                end
                CONVERT: begin
                    bcd   <= {bcd[8], adj, sh[7]};
                    sh    <= {sh[6:0], 1'b0};
                    iter  <= iter + 3'd1;
                    state <= iter == 3'd7 ? LOAD : CONVERT;
                end
                LOAD: begin
                    // a nonzero hundreds digit means the value exceeded 99
                    o_Tens_Num <= |bcd[9:8] ? 4'hE : bcd[7:4];
                    o_Ones_Num <= |bcd[9:8] ? 4'hE : bcd[3:0];
                    tens_blank <= LEADING_ZERO_BLANK && !(|bcd[9:8]) && bcd[7:4] == 4'd0;
                    o_Done     <= 1'b1;
                    o_Ready    <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!i_Blink) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == CW'(BLINK_HALF_PERIOD - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign o_Ones_En = ~phase;
    assign o_Tens_En = ~phase & ~tens_blank;
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed checks of conversion latency, digit codes, blanking,
// DV-while-busy rejection, blink timing and mid-conversion reset.
module tb_display_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] value = 8'd0;
    logic       dv = 1'b0;
    logic       blink = 1'b0;
    logic       ready, tens_en, ones_en, done;
    logic [3:0] tens, ones;
    logic       ready0, tens_en0, ones_en0, done0;
    logic [3:0] tens0, ones0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    display_scheduler #(.BLINK_HALF_PERIOD(4), .LEADING_ZERO_BLANK(1)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Value(value), .i_Value_DV(dv), .o_Ready(ready),
        .i_Blink(blink), .o_Tens_Num(tens), .o_Ones_Num(ones), .o_Tens_En(tens_en),
        .o_Ones_En(ones_en), .o_Done(done)
    );

    display_scheduler #(.BLINK_HALF_PERIOD(4), .LEADING_ZERO_BLANK(0)) dut0 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Value(value), .i_Value_DV(dv), .o_Ready(ready0),
        .i_Blink(blink), .o_Tens_Num(tens0), .o_Ones_Num(ones0), .o_Tens_En(tens_en0),
        .o_Ones_En(ones_en0), .o_Done(done0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [7:0] v, input logic [3:0] et, input logic [3:0] eo,
                       input logic ete, input logic ete0);
        value = v;
        dv = 1'b1;
        tick;
        dv = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check("busy_ready", ready, 0);
            check("busy_done", done, 0);
            tick;
        end
        check("e9_ready", ready, 1);
        check("e9_done", done, 1);
        check("e9_tens", tens, et);
        check("e9_ones", ones, eo);
        check("e9_ones_en", ones_en, 1);
        check("e9_tens_en", tens_en, ete);
        check("e9_tens0", tens0, et);
        check("e9_tens_en0", tens_en0, ete0);
        check("e9_ready0", ready0, 1);
        check("e9_done0", done0, 1);
        tick;
        check("e10_done", done, 0);
        check("e10_tens_hold", tens, et);
        check("e10_ones_hold", ones, eo);
    endtask

    initial begin
        tick;
        check("rst_ready", ready, 1);
        check("rst_tens", tens, 0);
        check("rst_ones", ones, 0);
        check("rst_done", done, 0);
        check("rst_ones_en", ones_en, 1);
        check("rst_tens_en", tens_en, 0);
        check("rst_tens_en0", tens_en0, 1);
        check("rst_ones_en0", ones_en0, 1);
        #3 rst_n = 1'b1;
        tick;
        run(8'd47, 4'd4, 4'd7, 1'b1, 1'b1);
        run(8'd5, 4'd0, 4'd5, 1'b0, 1'b1);
        run(8'd150, 4'hE, 4'hE, 1'b1, 1'b1);
        run(8'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        run(8'd99, 4'd9, 4'd9, 1'b1, 1'b1);
        // 25 accepted, 63 offered while busy must be dropped
        value = 8'd25;
        dv = 1'b1;
        tick;
        dv = 1'b0;
        tick;
        tick;
        value = 8'd63;
        dv = 1'b1;
        tick;
        dv = 1'b0;
        for (int k = 3; k < 9; k++) tick;
        check("ign_done", done, 1);
        check("ign_tens", tens, 2);
        check("ign_ones", ones, 5);
        run(8'd63, 4'd6, 4'd3, 1'b1, 1'b1);
        blink = 1'b1;
        check("blink_start", ones_en, 1);
        for (int i = 1; i < 14; i++) begin
            tick;
            check("blink_ones_en", ones_en, ((i / 4) % 2) == 0);
            check("blink_tens_en", tens_en, ((i / 4) % 2) == 0);
        end
        check("blink_ready", ready, 1);
        check("blink_tens_code", tens, 6);
        blink = 1'b0;
        tick;
        check("unblink_ones_en", ones_en, 1);
        check("unblink_tens_en", tens_en, 1);
        // reset lands between E4 and E5 of a conversion
        value = 8'd88;
        dv = 1'b1;
        tick;
        dv = 1'b0;
        for (int k = 0; k < 4; k++) tick;
        #3 rst_n = 1'b0;
        #1;
        check("abort_ready", ready, 1);
        check("abort_tens", tens, 0);
        check("abort_ones", ones, 0);
        check("abort_done", done, 0);
        check("abort_tens_en", tens_en, 0);
        check("abort_ones_en", ones_en, 1);
        for (int k = 0; k < 6; k++) begin
            tick;
            check("abort_hold_done", done, 0);
        end
        rst_n = 1'b1;
        #2;
        for (int k = 0; k < 6; k++) begin
            check("post_rst_done", done, 0);
            check("post_rst_ready", ready, 1);
            if (k < 5) tick;
        end
        run(8'd99, 4'd9, 4'd9, 1'b1, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 The block SHALL have parameter BLINK_HALF_PERIOD, default 12500000, the number of clocks per blink half-period (minimum 2).
REQ-002 The block SHALL have parameter LEADING_ZERO_BLANK, default 1; when 1, a zero tens digit is blanked.
REQ-003 The block SHALL have port i_Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_Rst_L, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port i_Value, input, 8 bits: unsigned binary value to display (credit, 0-99 valid).
REQ-006 The block SHALL have port i_Value_DV, input, 1 bit: i_Value valid this cycle.
REQ-007 The block SHALL have port o_Ready, output, 1 bit: block can accept a value.
REQ-008 The block SHALL have port i_Blink, input, 1 bit: level; when 1, the display flashes.
REQ-009 The block SHALL have port o_Tens_Num, output, 4 bits: tens digit code for the seven-segment decoder.
REQ-010 The block SHALL have port o_Ones_Num, output, 4 bits: ones digit code for the seven-segment decoder.
REQ-011 The block SHALL have port o_Tens_En, output, 1 bit: tens digit lit.
REQ-012 The block SHALL have port o_Ones_En, output, 1 bit: ones digit lit.
REQ-013 The block SHALL have port o_Done, output, 1 bit: one-cycle pulse when new digits are loaded.

Function
REQ-014 The FSM SHALL have states IDLE, CONVERT and LOAD; o_Ready SHALL be 1 only in IDLE.
REQ-015 A value SHALL be accepted on a rising edge where i_Value_DV=1 and o_Ready=1. i_Value SHALL be captured into a shift register, the BCD accumulator cleared, an iteration counter set to 0, and the FSM SHALL move to CONVERT.
REQ-016 i_Value_DV while not in IDLE SHALL be ignored; there SHALL be no queueing.
REQ-017 CONVERT SHALL perform one double-dabble iteration per clock for exactly 8 clocks. Each iteration: add 3 to any BCD nibble >= 5, then shift left by one, taking in the binary MSB. The FSM SHALL then go to LOAD.
REQ-018 LOAD SHALL last one clock and write o_Tens_Num/o_Ones_Num from the BCD result, then return to IDLE.
REQ-019 If the captured value is > 99, LOAD SHALL write o_Tens_Num=4'hE and o_Ones_Num=4'hE (error display) instead.
REQ-020 Latency SHALL be fixed: with acceptance at edge E0, outputs and the o_Done pulse change at edge E9, and o_Ready returns to 1 at E9.
REQ-021 o_Done SHALL be 1 for exactly the one cycle following the LOAD edge.
REQ-022 Digit outputs SHALL hold their last loaded values at all other times.
REQ-023 Base enables: o_Ones_En=1. o_Tens_En=0 if LEADING_ZERO_BLANK=1, the tens digit=0 and there is no error; otherwise o_Tens_En=1.
REQ-024 Blink: a free counter SHALL run 0..BLINK_HALF_PERIOD-1 and toggle a phase bit at terminal count. While i_Blink=0, the counter and phase SHALL be held at 0 (phase 0 = visible).
REQ-025 When the phase is 1, both enables SHALL be 0; blink SHALL NOT affect the digit codes, the FSM or o_Ready.
REQ-026 Rising i_Blink SHALL start with a visible half-period of full BLINK_HALF_PERIOD length.
REQ-027 Blink SHALL run independently of the conversion in progress.

Reset
REQ-028 While i_Rst_L=0, the block SHALL hold FSM=IDLE, o_Ready=1, o_Tens_Num=0, o_Ones_Num=0, o_Done=0, o_Ones_En=1, o_Tens_En=(LEADING_ZERO_BLANK?0:1), blink counter=0 and phase=0.
REQ-029 Reset asserted mid-CONVERT SHALL abort the conversion without producing an o_Done pulse; the first cycle after release SHALL accept a new value.

Verification
REQ-030 Bench SHALL check: i_Value=47 with DV for one cycle -> o_Ready low for 9 cycles; at E9 Tens=4, Ones=7, both enables 1, o_Done high for one cycle.
REQ-031 Bench SHALL check: i_Value=5 -> Tens=0, Ones=5, o_Tens_En=0 (LEADING_ZERO_BLANK=1), and o_Tens_En=1 with the parameter set to 0.
REQ-032 Bench SHALL check: i_Value=150 -> Tens=E, Ones=E, both enables 1; i_Value=99 -> 9,9; i_Value=0 -> 0,0 with tens blanked.
REQ-033 Bench SHALL check: 25 accepted, then DV with 63 at E3 -> 63 ignored; outputs show 25 at E9; 63 re-presented at E9 is accepted.
REQ-034 Bench SHALL check: BLINK_HALF_PERIOD=4, i_Blink=1 -> enables 1 for 4 cycles, then 0 for 4, repeating; i_Blink=0 -> enables restored the next cycle.
REQ-035 Bench SHALL check: reset pulse at E5 of a conversion -> outputs at reset values immediately, no o_Done pulse, o_Ready=1.
